// File: rtl/next_pc_pkg.sv
// Purpose: shared encodings for the next-PC select unit (JumpOP, BrCond, flush-window FSM).
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
// Contents: jop_e (PC mux select), brcond_e (branch condition), win_state_e (window FSM),
//           br_cond_met() evaluates a branch condition against the ALU flags.
package next_pc_pkg;

    typedef enum logic [1:0] {
        JOP_PC4 = 2'd0,
        JOP_BR  = 2'd1,
        JOP_JR  = 2'd2,
        JOP_J   = 2'd3
    } jop_e;

    typedef enum logic [1:0] {
        BC_EQ  = 2'd0,
        BC_NE  = 2'd1,
        BC_LTZ = 2'd2,
        BC_GEZ = 2'd3
    } brcond_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } win_state_e;

    function automatic logic br_cond_met(input brcond_e bc, input logic zero, input logic neg);
        logic met;
        case (bc)
            BC_EQ:   met = zero;
            BC_NE:   met = ~zero;
            BC_LTZ:  met = neg;
            default: met = ~neg;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Purpose: circular return-address stack; push overwrites the oldest entry when full.
// Latency: push/pop take effect on the clock edge; top/valid reflect the new state one cycle later.
// Backpressure: none; callers gate push/pop themselves, overflow/underflow are flagged sticky.
// Ports: clk_i, rst_ni (async active-low), push_i/push_dat_i (write return address),
//        pop_i (discard top), top_o/valid_o (current top, 0 when empty), ovf_o/unf_o (sticky).
module ret_addr_stack
    import next_pc_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [PC_W-1:0] push_dat_i,
    input  logic            pop_i,
    output logic [PC_W-1:0] top_o,
    output logic            valid_o,
    output logic            ovf_o,
    output logic            unf_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [PC_W-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, wr_ptr;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            wr_en;

    // ptr_q addresses the current top; a push lands one slot above it. Because the
    // depth is a power of two the pointer wraps for free, so a push while full
    // simply overwrites the oldest entry.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_ptr = ptr_q + PW'(1);
        if (push_i) begin
            wr_en = 1'b1;
            ptr_d = wr_ptr;
            if (cnt_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop_i) begin
            if (cnt_q == '0) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (wr_en) begin
                mem_q[wr_ptr] <= push_dat_i;
            end
        end
    end

    assign valid_o = (cnt_q != '0);
    assign top_o   = valid_o ? mem_q[ptr_q] : '0;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: rtl/next_pc_ctrl.sv
// Purpose: next-PC select (branch > JR > J priority), wrong-path flush window, return-address stack.
// Latency: JumpOP/Flush combinational from decode inputs; Busy and RAS views update one cycle after acceptance.
// Backpressure: Stall freezes all state; while Busy the decode slot is squashed and ignored.
// Ports: clk, rst (async active-low); Valid/Stall/Branch/BrCond/Zero/Neg/Jr/Jump/Link/PCPlus4 in;
//        JumpOP (PC mux select), Flush, Busy, RasTop, RasValid, RasOverflow, RasUnderflow out.
module next_pc_ctrl
    import next_pc_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int RAS_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Valid,
    input  logic            Stall,
    input  logic            Branch,
    input  logic [1:0]      BrCond,
    input  logic            Zero,
    input  logic            Neg,
    input  logic            Jr,
    input  logic            Jump,
    input  logic            Link,
    input  logic [PC_W-1:0] PCPlus4,
    output logic [1:0]      JumpOP,
    output logic            Flush,
    output logic            Busy,
    output logic [PC_W-1:0] RasTop,
    output logic            RasValid,
    output logic            RasOverflow,
    output logic            RasUnderflow
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    win_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy;
    logic       acc;
    logic       taken;
    logic       redirect;
    logic       ras_push;
    logic       ras_pop;
    jop_e       jop;

    assign busy = (cnt_q != 3'd0);

    // rst is folded in so JumpOP/Flush read 0 the instant reset asserts, even
    // with a valid instruction still sitting on the decode inputs.
    assign acc   = rst & Valid & ~Stall & ~busy;
    assign taken = Branch & br_cond_met(brcond_e'(BrCond), Zero, Neg);

    always_comb begin
        jop = JOP_PC4;
        if (acc) begin
            if (taken) begin
                jop = JOP_BR;
            end else if (Jr) begin
                jop = JOP_JR;
            end else if (Jump) begin
                jop = JOP_J;
            end
        end
    end

    assign redirect = (jop != JOP_PC4);
    assign JumpOP   = jop;
    assign Flush    = redirect | busy;
    assign Busy     = busy;

    // Window FSM. A redirect can only happen from IDLE (acc needs !busy), and
    // redirect already implies !Stall, so only FLUSH needs to honour Stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect && (FLUSH_CYCLES > 0)) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (!Stall) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A taken branch wins over Jr/Jump and thereby suppresses any RAS op.
    // JALR (Jr & Link) is treated as a call only: push, no pop.
    assign ras_push = Link & ((jop == JOP_J) | (jop == JOP_JR));
    assign ras_pop  = (jop == JOP_JR) & ~Link;

    ret_addr_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i      (clk),
        .rst_ni     (rst),
        .push_i     (ras_push),
        .push_dat_i (PCPlus4),
        .pop_i      (ras_pop),
        .top_o      (RasTop),
        .valid_o    (RasValid),
        .ovf_o      (RasOverflow),
        .unf_o      (RasUnderflow)
    );

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Purpose: self-checking bench for next_pc_ctrl (PC_W=32, RAS_DEPTH=4, FLUSH_CYCLES=2).
// Latency: each step drives one decode cycle, checks outputs 1 time unit later, before the edge.
// Backpressure: n/a; stall and busy windows are exercised explicitly.
module tb_next_pc_ctrl;
    import next_pc_pkg::*;

    localparam int PC_W         = 32;
    localparam int RAS_DEPTH    = 4;
    localparam int FLUSH_CYCLES = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            Valid, Stall, Branch, Zero, Neg, Jr, Jump, Link;
    logic [1:0]      BrCond;
    logic [PC_W-1:0] PCPlus4;
    logic [1:0]      JumpOP;
    logic            Flush, Busy, RasValid, RasOverflow, RasUnderflow;
    logic [PC_W-1:0] RasTop;

    always #5 clk = ~clk;

    next_pc_ctrl #(
        .PC_W         (PC_W),
        .RAS_DEPTH    (RAS_DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Valid        (Valid),
        .Stall        (Stall),
        .Branch       (Branch),
        .BrCond       (BrCond),
        .Zero         (Zero),
        .Neg          (Neg),
        .Jr           (Jr),
        .Jump         (Jump),
        .Link         (Link),
        .PCPlus4      (PCPlus4),
        .JumpOP       (JumpOP),
        .Flush        (Flush),
        .Busy         (Busy),
        .RasTop       (RasTop),
        .RasValid     (RasValid),
        .RasOverflow  (RasOverflow),
        .RasUnderflow (RasUnderflow)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: window counter plus a queue-based stack (back = top).
    int          win_m = 0;
    logic [31:0] ras_m[$];
    logic        ovf_m = 1'b0;
    logic        unf_m = 1'b0;

    typedef struct {
        string       tag;
        logic [1:0]  jop;
        logic        flush;
        logic        busy;
        logic [31:0] top;
        logic        rv;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];

    task automatic model_reset();
        win_m = 0;
        ras_m.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    // One decode cycle. want >= 0 adds a hand-derived JumpOP expectation.
    task automatic step(input string tag, input logic v, input logic st, input logic br,
                        input logic [1:0] bc, input logic z, input logic n, input logic j_r,
                        input logic jmp, input logic lk, input logic [31:0] pc, input int want);
        exp_t       e;
        exp_t       g;
        logic       acc;
        logic       tk;
        logic [1:0] jop;
        @(negedge clk);
        Valid = v; Stall = st; Branch = br; BrCond = bc; Zero = z; Neg = n;
        Jr = j_r; Jump = jmp; Link = lk; PCPlus4 = pc;

        acc = v & ~st & (win_m == 0);
        case (bc)
            2'd0:    tk = br & z;
            2'd1:    tk = br & ~z;
            2'd2:    tk = br & n;
            default: tk = br & ~n;
        endcase
        if (!acc)     jop = 2'd0;
        else if (tk)  jop = 2'd1;
        else if (j_r) jop = 2'd2;
        else if (jmp) jop = 2'd3;
        else          jop = 2'd0;
        e.tag   = tag;
        e.jop   = jop;
        e.flush = (jop != 2'd0) || (win_m != 0);
        e.busy  = (win_m != 0);
        e.rv    = (ras_m.size() != 0);
        e.top   = 32'h0;
        if (ras_m.size() != 0) e.top = ras_m[ras_m.size() - 1];
        e.ovf   = ovf_m;
        e.unf   = unf_m;
        exp_q.push_back(e);

        #1;
        g = exp_q.pop_front();
        check({g.tag, ".jop"},   32'(JumpOP),       32'(g.jop));
        check({g.tag, ".flush"}, 32'(Flush),        32'(g.flush));
        check({g.tag, ".busy"},  32'(Busy),         32'(g.busy));
        check({g.tag, ".top"},   RasTop,            g.top);
        check({g.tag, ".rv"},    32'(RasValid),     32'(g.rv));
        check({g.tag, ".ovf"},   32'(RasOverflow),  32'(g.ovf));
        check({g.tag, ".unf"},   32'(RasUnderflow), 32'(g.unf));
        if (want >= 0) check({tag, ".want"}, 32'(JumpOP), 32'(want));

        if ((jop == 2'd2 || jop == 2'd3) && lk) begin
            if (ras_m.size() == RAS_DEPTH) begin
                void'(ras_m.pop_front());
                ovf_m = 1'b1;
            end
            ras_m.push_back(pc);
        end else if (jop == 2'd2) begin
            if (ras_m.size() == 0) unf_m = 1'b1;
            else void'(ras_m.pop_back());
        end
        if (!st) begin
            if (win_m != 0)       win_m--;
            else if (jop != 2'd0) win_m = FLUSH_CYCLES;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic do_jal(input string tag, input logic [31:0] pc);
        step(tag, 1, 0, 0, 2'd0, 0, 0, 0, 1, 1, pc, 3);
        idle(FLUSH_CYCLES);
    endtask

    task automatic do_jr(input string tag);
        step(tag, 1, 0, 0, 2'd0, 0, 0, 1, 0, 0, 32'h0, 2);
        idle(FLUSH_CYCLES);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        Valid = 0; Stall = 0; Branch = 0; BrCond = 2'd0; Zero = 0; Neg = 0;
        Jr = 0; Jump = 0; Link = 0; PCPlus4 = '0;
        #2;
        check("rst.jop",   32'(JumpOP),       0);
        check("rst.flush", 32'(Flush),        0);
        check("rst.busy",  32'(Busy),         0);
        check("rst.top",   RasTop,            0);
        check("rst.rv",    32'(RasValid),     0);
        check("rst.ovf",   32'(RasOverflow),  0);
        check("rst.unf",   32'(RasUnderflow), 0);
        #10 rst = 1'b1;

        // Priority: taken branch beats Jr and Jump; Link present but no RAS op.
        step("prio", 1, 0, 1, 2'd0, 1, 0, 1, 1, 1, 32'h200, 1);
        check("prio.flush_now", 32'(Flush), 1);
        idle(FLUSH_CYCLES);
        step("prio_after", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0, 0);
        check("prio.no_push", 32'(RasValid), 0);

        // Branch conditions.
        step("bne_z1", 1, 0, 1, 2'd1, 1, 0, 0, 0, 0, 32'h0, 0);
        step("beq_z0", 1, 0, 1, 2'd0, 0, 0, 0, 0, 0, 32'h0, 0);
        step("bltz_n1", 1, 0, 1, 2'd2, 0, 1, 0, 0, 0, 32'h0, 1);
        idle(FLUSH_CYCLES);
        step("bgez_n1", 1, 0, 1, 2'd3, 0, 1, 0, 0, 0, 32'h0, 0);
        step("bgez_n0", 1, 0, 1, 2'd3, 0, 0, 0, 0, 0, 32'h0, 1);
        idle(FLUSH_CYCLES);
        step("invalid_j", 0, 0, 0, 2'd0, 0, 0, 0, 1, 0, 32'h0, 0);
        step("stalled_j", 1, 1, 0, 2'd0, 0, 0, 0, 1, 0, 32'h0, 0);

        // Flush window, no stall.
        step("win_j", 1, 0, 0, 2'd0, 0, 0, 0, 1, 0, 32'h0, 3);
        step("win_t1", 1, 0, 0, 2'd0, 0, 0, 1, 0, 0, 32'h0, 0);
        check("win.busy_t1", 32'(Busy), 1);
        step("win_t2", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0, 0);
        check("win.busy_t2", 32'(Busy), 1);
        step("win_t3", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0, 0);
        check("win.busy_t3", 32'(Busy), 0);

        // Flush window with a stall at t+1: extends by one cycle.
        step("wst_j", 1, 0, 0, 2'd0, 0, 0, 0, 1, 0, 32'h0, 3);
        step("wst_t1", 1, 1, 0, 2'd0, 0, 0, 0, 1, 0, 32'h0, 0);
        step("wst_t2", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0, 0);
        step("wst_t3", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0, 0);
        check("wst.busy_t3", 32'(Busy), 1);
        step("wst_t4", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0, 0);
        check("wst.busy_t4", 32'(Busy), 0);

        // RAS: call, return, underflow.
        do_jal("jal100", 32'h100);
        check("ras.top100", RasTop, 32'h100);
        check("ras.rv1", 32'(RasValid), 1);
        do_jr("jr_pop");
        check("ras.rv0", 32'(RasValid), 0);
        do_jr("jr_unf");
        check("ras.unf", 32'(RasUnderflow), 1);
        check("ras.unf_rv", 32'(RasValid), 0);

        // JALR pushes only.
        step("jalr", 1, 0, 0, 2'd0, 0, 0, 1, 0, 1, 32'h300, 2);
        idle(FLUSH_CYCLES);
        check("jalr.top", RasTop, 32'h300);
        do_jr("jalr_ret");

        // Overflow: five calls into a four-deep stack.
        for (int i = 1; i <= 5; i++) do_jal("jal_ovf", 32'(i * 16));
        check("ovf.flag", 32'(RasOverflow), 1);
        for (int i = 5; i >= 2; i--) begin
            check("ovf.pop_top", RasTop, 32'(i * 16));
            do_jr("jr_ovf");
        end
        check("ovf.empty", 32'(RasValid), 0);

        // Asynchronous reset in the middle of a window with the RAS non-empty.
        do_jal("jal_pre", 32'h500);
        step("rst_j", 1, 0, 0, 2'd0, 0, 0, 0, 1, 1, 32'h77, 3);
        @(negedge clk);
        Valid = 1; Jump = 1;
        #1;
        check("pre_rst.busy", 32'(Busy), 1);
        #1 rst = 1'b0;
        #1;
        model_reset();
        check("arst.busy",  32'(Busy),         0);
        check("arst.flush", 32'(Flush),        0);
        check("arst.jop",   32'(JumpOP),       0);
        check("arst.rv",    32'(RasValid),     0);
        check("arst.top",   RasTop,            0);
        check("arst.ovf",   32'(RasOverflow),  0);
        check("arst.unf",   32'(RasUnderflow), 0);
        Valid = 0; Jump = 0;
        #1 rst = 1'b1;
        step("post_rst_j", 1, 0, 0, 2'd0, 0, 0, 0, 1, 0, 32'h0, 3);
        idle(FLUSH_CYCLES + 1);

        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard: %0d entries left", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
